dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port (`dmem_top`) between the core datapath and a host/debug master (program loader, test harness). The block sits between the datapath's load/store signals and `dmem_top`. It grants one requester per access, sequences the memory's fixed read latency, and stalls the core while the core is not being served. An optional starvation counter keeps a busy core from locking the host out.

## Interface
Parameters:
- `RD_LAT`, default 1: read latency of `dmem_top` in cycles (1–7).
- `STARVE_MAX`, default 8: consecutive host-wait cycles before the host gets priority (fair mode only).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `core_req`  in  1  core memory access (MemRead|MemWrite).
- `core_we`  in  1  core write, 0 = read.
- `core_addr`  in  64  byte address.
- `core_wdata`  in  64  store data.
- `core_func3`  in  3  size/sign code passed through.
- `core_stall`  out  1  hold PC and register write-back.
- `core_rdata`  out  64  load data.
- `core_rvalid`  out  1  load data valid, one-cycle pulse.
- `host_req` / `host_we` / `host_addr`[64] / `host_wdata`[64] / `host_func3`[3]  in: host access, same meaning as the core signals.
- `host_gnt`  out  1  host access accepted this cycle.
- `host_rdata`  out  64  host read data.
- `host_rvalid`  out  1  host read data valid, one-cycle pulse.
- `mem_we` / `mem_re`  out  1  to `dmem_top` we/re.
- `mem_addr`  out  64  to `dmem_top`.
- `mem_data`  out  64  to `dmem_top`.
- `mem_func3`  out  3  to `dmem_top`.
- `mem_rdata`  in  64  from `dmem_top` out_data.

## Operation
- States: IDLE, RD_CORE, RD_HOST.
- IDLE: selects the winner combinationally and drives the `mem_*` signals from the winner in the same cycle.
- Priority: the core wins by default. In fair mode the host wins when its wait counter is ≥ `STARVE_MAX`.
- Write by winner: performed in that cycle; state stays IDLE.
  - Core wins: `core_stall`=0.
  - Host wins: `host_gnt`=1.
- Read by winner: `mem_re`=1 for one cycle, then go to RD_CORE or RD_HOST with the latency counter loaded to `RD_LAT`.
  - `host_gnt` pulses on acceptance.
- RD_x: the counter decrements each cycle and `mem_*` is held idle (we=re=0).
  - At count 1, capture `mem_rdata` into `x_rdata`, pulse `x_rvalid`, and return to IDLE.
  - The core's read completes in that cycle, so `core_stall`=0 in that cycle only.
- `core_stall` = `core_req` AND NOT (core write accepted this cycle OR core read completing this cycle).
- A losing requester is not acknowledged and must hold its signals stable.
- Requests arriving during RD_x are not served until IDLE. A core load followed by another core load takes 1+`RD_LAT` cycles each.
- Wait counter: saturating at `STARVE_MAX`.
  - Increments each cycle `host_req`=1 and the host is not granted.
  - Clears on `host_gnt`.
- `x_rdata` holds its value until the next read completion.

## Timing
- Reset values: state IDLE, counters 0, `core_rdata`/`host_rdata` 0, `core_rvalid`/`host_rvalid`/`host_gnt` 0.
- During reset: `mem_we`/`mem_re` 0 and `core_stall` 0.
- Write latency 0 cycles: same-cycle grant.
- Read latency `RD_LAT`+1 cycles from request to `rvalid`.
- Simultaneous core and host request in IDLE: exactly one is granted, never both. `mem_we` and `mem_re` are never both 1.
- Reset asserted mid-read: the read is abandoned, no `rvalid` is issued, and the block is in IDLE on deassert.
- Latency counter width: 3 bits. Starvation counter width: ceil(log2(`STARVE_MAX`+1)) bits.

## Configuration
- `DMEM_ARB_FAIR_EN` defined: the starvation counter and host-priority override are compiled in.
- Undefined: fixed core priority, no counter, and the host is served only in IDLE cycles with `core_req`=0.

## Test plan
- Core store, addr 0x10, wdata 0xDEADBEEF, host idle → `mem_we`=1, `mem_addr`=0x10 in the same cycle; `core_stall`=0.
- Core load with `RD_LAT`=1, `mem_rdata`=0x1234 → `core_stall`=1 for 1 cycle; `core_rvalid` and `core_rdata`=0x1234 in cycle 2; `core_stall`=0 in cycle 2.
- Core and host request loads together → core served first; `host_gnt` in the first IDLE after `core_rvalid`.
- Fair mode, `STARVE_MAX`=8, core_req held 1 with back-to-back stores, host_req held 1 → `host_gnt` on the 9th cycle while `core_stall`=1 that cycle. Without the macro, no `host_gnt` ever.
- Reset low during RD_HOST → no `host_rvalid`; after reset release, all outputs are at their reset values and state is IDLE.
- Host write then host read of addr 0x40, value 0xA5 → `host_rvalid` with `host_rdata`=0xA5.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares dmem_top between the core datapath and a host/debug master.
// Optional macro DMEM_ARB_FAIR_EN adds a host starvation counter that overrides core priority.
module dmem_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [63:0] core_addr,
    input  logic [63:0] core_wdata,
    input  logic [2:0]  core_func3,
    output logic        core_stall,
    output logic [63:0] core_rdata,
    output logic        core_rvalid,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [63:0] host_addr,
    input  logic [63:0] host_wdata,
    input  logic [2:0]  host_func3,
    output logic        host_gnt,
    output logic [63:0] host_rdata,
    output logic        host_rvalid,
    output logic        mem_we,
    output logic        mem_re,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_data,
    output logic [2:0]  mem_func3,
    input  logic [63:0] mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_CORE = 2'd1;
    localparam logic [1:0] RD_HOST = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [63:0] coreRdata_q, hostRdata_q;

    logic        isIdle;
    logic        hostPrio;
    logic        coreWin, hostWin, anyWin;
    logic        selWe;
    logic [63:0] selAddr, selWdata;
    logic [2:0]  selFunc3;
    logic        coreRdDone, hostRdDone;

`ifdef DMEM_ARB_FAIR_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starve_q, starve_d;

    assign hostPrio = host_req && (starve_q >= STARVE_W'(STARVE_MAX));

    // Host wait counter saturates so the priority override stays asserted until served.
    always_comb begin
        starve_d = starve_q;
        if (host_gnt) begin
            starve_d = '0;
        end else if (host_req && (starve_q < STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign hostPrio = 1'b0;
`endif

    assign isIdle     = (state_q == IDLE);
    assign coreWin    = isIdle && core_req && !hostPrio;
    assign hostWin    = isIdle && host_req && !coreWin;
    assign anyWin     = coreWin || hostWin;
    assign selWe      = coreWin ? core_we    : host_we;
    assign selAddr    = coreWin ? core_addr  : host_addr;
    assign selWdata   = coreWin ? core_wdata : host_wdata;
    assign selFunc3   = coreWin ? core_func3 : host_func3;
    assign coreRdDone = (state_q == RD_CORE) && (lat_q == 3'd1);
    assign hostRdDone = (state_q == RD_HOST) && (lat_q == 3'd1);

    // Outputs are gated by reset so nothing reaches memory or the host while reset is low.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        mem_func3 = '0;
        if (reset && anyWin) begin
            mem_we    = selWe;
            mem_re    = !selWe;
            mem_addr  = selAddr;
            mem_data  = selWdata;
            mem_func3 = selFunc3;
        end
    end

    assign host_gnt    = reset && hostWin;
    assign core_rvalid = reset && coreRdDone;
    assign host_rvalid = reset && hostRdDone;
    assign core_rdata  = core_rvalid ? mem_rdata : coreRdata_q;
    assign host_rdata  = host_rvalid ? mem_rdata : hostRdata_q;
    assign core_stall  = reset && core_req && !((coreWin && core_we) || coreRdDone);

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (anyWin && !selWe) begin
                    state_d = coreWin ? RD_CORE : RD_HOST;
                    lat_d   = 3'(RD_LAT);
                end
            end
            RD_CORE, RD_HOST: begin
                if (lat_q <= 3'd1) begin
                    state_d = IDLE;
                    lat_d   = 3'd0;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                lat_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lat_q       <= 3'd0;
            coreRdata_q <= '0;
            hostRdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (coreRdDone) begin
                coreRdata_q <= mem_rdata;
            end
            if (hostRdDone) begin
                hostRdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed plan scenarios plus random traffic, checked cycle by
// cycle against a transaction-level model with its own shadow memory.
module tb_dmem_arbiter;

    localparam int RD_LAT     = 1;
    localparam int STARVE_MAX = 8;
`ifdef DMEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        core_req, core_we;
    logic [63:0] core_addr, core_wdata;
    logic [2:0]  core_func3;
    logic        core_stall, core_rvalid;
    logic [63:0] core_rdata;
    logic        host_req, host_we;
    logic [63:0] host_addr, host_wdata;
    logic [2:0]  host_func3;
    logic        host_gnt, host_rvalid;
    logic [63:0] host_rdata;
    logic        mem_we, mem_re;
    logic [63:0] mem_addr, mem_data, mem_rdata;
    logic [2:0]  mem_func3;

    int checkCount = 0;
    int passCount  = 0;

    dmem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_func3(core_func3),
        .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_func3(host_func3),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in with RD_LAT read pipeline; non-read cycles produce junk data.
    logic [63:0] memArr [16];
    logic [63:0] rdPipe [RD_LAT];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) memArr[i] <= 64'h1000 + 64'(i);
        end else if (mem_we) begin
            memArr[mem_addr[6:3]] <= mem_data;
        end
        rdPipe[0] <= mem_re ? memArr[mem_addr[6:3]] : {$urandom, $urandom};
        for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end

    assign mem_rdata = rdPipe[RD_LAT-1];

    // Transaction model state: remaining read cycles, read owner, host wait time, shadow memory.
    int          mBusy, nBusy;
    bit          mOwnerHost, nOwnerHost;
    int          mWait, nWait;
    logic [63:0] mPend, nPend, mCoreData, nCoreData, mHostData, nHostData;
    logic [63:0] shadow [16];
    bit          shWrite;
    logic [3:0]  shIdx;
    logic [63:0] shVal;

    logic        expWe, expRe, expGnt, expCV, expHV, expStall;
    logic [63:0] expAddr, expData, expCoreRdata, expHostRdata;
    logic [2:0]  expF3;
    bit          coreAck, hostAck;
    logic        obsGnt, obsHV;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    task modelReset();
        mBusy = 0; mOwnerHost = 0; mWait = 0;
        mPend = '0; mCoreData = '0; mHostData = '0;
        for (int i = 0; i < 16; i++) shadow[i] = 64'h1000 + 64'(i);
    endtask

    task computeExpect();
        bit          hostFirst, useCore, useHost, w;
        logic [63:0] a, d;
        logic [2:0]  f;
        expWe = 0; expRe = 0; expGnt = 0; expCV = 0; expHV = 0; expStall = 0;
        expAddr = '0; expData = '0; expF3 = '0;
        coreAck = 0; hostAck = 0; shWrite = 0; shIdx = '0; shVal = '0;
        nBusy = mBusy; nOwnerHost = mOwnerHost; nWait = mWait;
        nPend = mPend; nCoreData = mCoreData; nHostData = mHostData;
        if (!reset) begin
            expCoreRdata = '0;
            expHostRdata = '0;
        end else begin
            if (mBusy == 0) begin
                hostFirst = FAIR && host_req && (mWait >= STARVE_MAX);
                useCore   = core_req && !hostFirst;
                useHost   = !useCore && host_req;
                if (useCore || useHost) begin
                    w = useCore ? core_we : host_we;
                    a = useCore ? core_addr : host_addr;
                    d = useCore ? core_wdata : host_wdata;
                    f = useCore ? core_func3 : host_func3;
                    expWe = w; expRe = !w; expAddr = a; expData = d; expF3 = f;
                    expGnt = useHost;
                    if (w) begin
                        shWrite = 1; shIdx = a[6:3]; shVal = d;
                        coreAck = useCore;
                    end else begin
                        nBusy = RD_LAT; nOwnerHost = useHost; nPend = shadow[a[6:3]];
                    end
                end
            end else begin
                if (mBusy == 1) begin
                    if (mOwnerHost) begin
                        expHV = 1; nHostData = mPend;
                    end else begin
                        expCV = 1; nCoreData = mPend; coreAck = 1;
                    end
                end
                nBusy = mBusy - 1;
            end
            expStall     = core_req && !coreAck;
            expCoreRdata = expCV ? mPend : mCoreData;
            expHostRdata = expHV ? mPend : mHostData;
            hostAck      = expGnt;
            if (expGnt) nWait = 0;
            else if (host_req && mWait < STARVE_MAX) nWait = mWait + 1;
        end
    endtask

    task checkAll();
        checkOutput("mem_we", mem_we, expWe);
        checkOutput("mem_re", mem_re, expRe);
        if (expWe || expRe) begin
            checkOutput("mem_addr", mem_addr, expAddr);
            checkOutput("mem_func3", mem_func3, expF3);
        end
        if (expWe) checkOutput("mem_data", mem_data, expData);
        checkOutput("host_gnt", host_gnt, expGnt);
        checkOutput("core_stall", core_stall, expStall);
        checkOutput("core_rvalid", core_rvalid, expCV);
        checkOutput("host_rvalid", host_rvalid, expHV);
        checkOutput("core_rdata", core_rdata, expCoreRdata);
        checkOutput("host_rdata", host_rdata, expHostRdata);
    endtask

    task runCycle();
        @(negedge clk);
        computeExpect();
        checkAll();
        obsGnt = host_gnt;
        obsHV  = host_rvalid;
        @(posedge clk);
        if (!reset) begin
            modelReset();
        end else begin
            mBusy = nBusy; mOwnerHost = nOwnerHost; mWait = nWait;
            mPend = nPend; mCoreData = nCoreData; mHostData = nHostData;
            if (shWrite) shadow[shIdx] = shVal;
        end
        #1;
    endtask

    task applyStimulus(input bit cReq, input bit cWe, input logic [63:0] cAddr, input logic [63:0] cWdata,
                       input bit hReq, input bit hWe, input logic [63:0] hAddr, input logic [63:0] hWdata);
        core_req = cReq; core_we = cWe; core_addr = cAddr; core_wdata = cWdata; core_func3 = 3'b011;
        host_req = hReq; host_we = hWe; host_addr = hAddr; host_wdata = hWdata; host_func3 = 3'b011;
    endtask

    task runUntilDone(input int maxCycles);
        int n;
        n = 0;
        while ((core_req || host_req) && n < maxCycles) begin
            runCycle();
            if (coreAck) core_req = 0;
            if (hostAck) host_req = 0;
            n++;
        end
        checkOutput("requests_drained", {62'b0, core_req, host_req}, 64'd0);
    endtask

    task genRandom();
        if (!core_req || coreAck) begin
            core_req   = ($urandom_range(0, 3) != 0);
            core_we    = $urandom_range(0, 1);
            core_addr  = {57'b0, 4'($urandom_range(0, 15)), 3'b0};
            core_wdata = {$urandom, $urandom};
            core_func3 = 3'($urandom_range(0, 7));
        end
        if (!host_req || hostAck) begin
            host_req   = $urandom_range(0, 1);
            host_we    = $urandom_range(0, 1);
            host_addr  = {57'b0, 4'($urandom_range(0, 15)), 3'b0};
            host_wdata = {$urandom, $urandom};
            host_func3 = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gntCycle;
        bit hvSeen;
        modelReset();
        obsGnt = 0; obsHV = 0; coreAck = 0; hostAck = 0;
        reset = 1'b0;
        applyStimulus(1, 0, 64'h10, 64'h0, 1, 0, 64'h18, 64'h0);
        repeat (3) runCycle();
        applyStimulus(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0);
        reset = 1'b1;
        runCycle();

        $display("[TB] core store then load");
        applyStimulus(1, 1, 64'h10, 64'hDEADBEEF, 0, 0, 64'h0, 64'h0);
        runUntilDone(4);
        applyStimulus(1, 1, 64'h18, 64'h1234, 0, 0, 64'h0, 64'h0);
        runUntilDone(4);
        applyStimulus(1, 0, 64'h18, 64'h0, 0, 0, 64'h0, 64'h0);
        runUntilDone(RD_LAT + 3);
        checkOutput("plan_core_rdata", core_rdata, 64'h1234);

        $display("[TB] simultaneous core and host loads");
        applyStimulus(1, 0, 64'h10, 64'h0, 1, 0, 64'h18, 64'h0);
        runUntilDone(4 * RD_LAT + 8);
        repeat (RD_LAT + 1) runCycle();
        checkOutput("plan_host_load", host_rdata, 64'h1234);

        $display("[TB] host write then read");
        applyStimulus(0, 0, 64'h0, 64'h0, 1, 1, 64'h40, 64'hA5);
        runUntilDone(4);
        applyStimulus(0, 0, 64'h0, 64'h0, 1, 0, 64'h40, 64'h0);
        runUntilDone(4);
        repeat (RD_LAT) runCycle();
        checkOutput("plan_host_rdata", host_rdata, 64'hA5);

        $display("[TB] starvation with back-to-back core stores");
        applyStimulus(1, 1, 64'h20, 64'h77, 1, 1, 64'h28, 64'h55);
        gntCycle = 0;
        for (int c = 1; c <= 12; c++) begin
            runCycle();
            if (obsGnt && gntCycle == 0) gntCycle = c;
            if (hostAck) host_req = 0;
        end
        checkOutput("plan_starve_gnt_cycle", gntCycle, FAIR ? 64'd9 : 64'd0);
        applyStimulus(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0);
        repeat (2) runCycle();

        $display("[TB] reset during host read");
        applyStimulus(0, 0, 64'h0, 64'h0, 1, 0, 64'h40, 64'h0);
        runCycle();
        applyStimulus(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0);
        reset = 1'b0;
        hvSeen = 0;
        repeat (RD_LAT + 1) begin
            runCycle();
            hvSeen = hvSeen | obsHV;
        end
        reset = 1'b1;
        runCycle();
        hvSeen = hvSeen | obsHV;
        checkOutput("plan_no_rvalid_after_reset", hvSeen, 64'd0);
        checkOutput("plan_rst_host_rdata", host_rdata, 64'd0);
        checkOutput("plan_rst_core_rdata", core_rdata, 64'd0);

        $display("[TB] random traffic");
        repeat (1500) begin
            genRandom();
            runCycle();
        end
        applyStimulus(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0);
        repeat (RD_LAT + 2) runCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
